// File: rtl/hdmi_period_scheduler.sv
// Per-pixel TMDS period scheduler: video periods decoded from cx/cy, data islands paced in hblank.
// Data islands exist only when HDMI_DATA_ISLAND_EN is defined; otherwise the block is DVI-only.
module hdmi_period_scheduler #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned FRAME_WIDTH   = 800,
  parameter int unsigned FRAME_HEIGHT  = 525,
  parameter int unsigned MAX_PACKETS   = 18
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic        packet_req,
  output logic        packet_ack,
  output logic [2:0]  mode,
  output logic [3:0]  ctl,
  output logic [4:0]  packet_pixel,
  output logic        guard_lead
);

  localparam logic [12:0] LP_SW = 13'(SCREEN_WIDTH);
  localparam logic [12:0] LP_SH = 13'(SCREEN_HEIGHT);
  localparam logic [12:0] LP_FW = 13'(FRAME_WIDTH);
  localparam logic [12:0] LP_FH = 13'(FRAME_HEIGHT);

  localparam logic [2:0] MODE_CTRL  = 3'd0;
  localparam logic [2:0] MODE_VPRE  = 3'd1;
  localparam logic [2:0] MODE_VGB   = 3'd2;
  localparam logic [2:0] MODE_VDATA = 3'd3;

  localparam logic [3:0] CTL_VPRE = 4'b0001;

  // All position arithmetic is done at 13 bits so cx+48 cannot wrap.
  logic [12:0] w_cx;
  logic [12:0] w_cy;
  assign w_cx = {1'b0, cx};
  assign w_cy = {2'b00, cy};

  logic w_video_next;
  logic w_vid_data;
  logic w_vid_pre;
  logic w_vid_gb;
  assign w_video_next = (w_cy == LP_FH - 13'd1) || (w_cy < LP_SH - 13'd1);
  assign w_vid_data   = (w_cx < LP_SW) && (w_cy < LP_SH);
  assign w_vid_pre    = w_video_next && (w_cx >= LP_FW - 13'd10) && (w_cx <= LP_FW - 13'd3);
  assign w_vid_gb     = w_video_next && (w_cx >= LP_FW - 13'd2) && (w_cx <= LP_FW - 13'd1);

  logic [2:0] w_vid_mode;
  logic [3:0] w_vid_ctl;
  always_comb begin
    w_vid_mode = MODE_CTRL;
    if (w_vid_data) begin
      w_vid_mode = MODE_VDATA;
    end else if (w_vid_pre) begin
      w_vid_mode = MODE_VPRE;
    end else if (w_vid_gb) begin
      w_vid_mode = MODE_VGB;
    end
  end
  assign w_vid_ctl = w_vid_pre ? CTL_VPRE : 4'b0000;

  logic [2:0] r_mode;
  logic [3:0] r_ctl;
  assign mode = r_mode;
  assign ctl  = r_ctl;

`ifdef HDMI_DATA_ISLAND_EN

  localparam logic [2:0] MODE_IPRE  = 3'd4;
  localparam logic [2:0] MODE_IGB   = 3'd5;
  localparam logic [2:0] MODE_IDATA = 3'd6;
  localparam logic [3:0] CTL_IPRE   = 4'b0101;

  localparam logic [12:0] LP_START = 13'(SCREEN_WIDTH + 4);
  localparam bit          LP_FITS  = (SCREEN_WIDTH + 62) <= FRAME_WIDTH;
  localparam logic [4:0]  LP_MAX   = 5'(MAX_PACKETS);

  typedef enum logic [2:0] {StCtrl, StPre, StLgb, StData, StTgb} state_e;

  state_e     r_state;
  logic [4:0] r_cnt;
  logic [4:0] r_sent;
  logic       r_ack;
  logic [4:0] r_pix;
  logic       r_lead;

  logic w_start;
  logic w_more;
  logic w_abort;
  assign w_start = LP_FITS && packet_req && (w_cx == LP_START);
  assign w_more  = packet_req && (r_sent < LP_MAX) && ((w_cx + 13'd1 + 13'd48) <= LP_FW);
  // A wrapped or jumped cx back into active video kills any island in flight.
  assign w_abort = (r_state != StCtrl) && (w_cx < LP_SW);

  // State and outputs describe the position presented on the previous cycle.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state <= StCtrl;
      r_cnt   <= '0;
      r_sent  <= '0;
      r_mode  <= MODE_CTRL;
      r_ctl   <= '0;
      r_ack   <= 1'b0;
      r_pix   <= '0;
      r_lead  <= 1'b0;
    end else begin
      r_state <= StCtrl;
      r_cnt   <= '0;
      r_mode  <= w_vid_mode;
      r_ctl   <= w_vid_ctl;
      r_ack   <= 1'b0;
      r_pix   <= '0;
      r_lead  <= 1'b0;
      if (!w_abort) begin
        unique case (r_state)
          StCtrl: begin
            if (w_start) begin
              r_state <= StPre;
              r_sent  <= '0;
              r_mode  <= MODE_IPRE;
              r_ctl   <= CTL_IPRE;
            end
          end
          StPre: begin
            if (r_cnt == 5'd7) begin
              r_state <= StLgb;
              r_mode  <= MODE_IGB;
              r_ctl   <= '0;
              r_lead  <= 1'b1;
            end else begin
              r_state <= StPre;
              r_cnt   <= r_cnt + 5'd1;
              r_mode  <= MODE_IPRE;
              r_ctl   <= CTL_IPRE;
            end
          end
          StLgb: begin
            r_ctl <= '0;
            if (r_cnt == 5'd1) begin
              r_state <= StData;
              r_mode  <= MODE_IDATA;
              r_ack   <= 1'b1;
              r_sent  <= r_sent + 5'd1;
            end else begin
              r_state <= StLgb;
              r_cnt   <= r_cnt + 5'd1;
              r_mode  <= MODE_IGB;
              r_lead  <= 1'b1;
            end
          end
          StData: begin
            r_ctl <= '0;
            if (r_cnt != 5'd31) begin
              r_state <= StData;
              r_cnt   <= r_cnt + 5'd1;
              r_pix   <= r_cnt + 5'd1;
              r_mode  <= MODE_IDATA;
            end else if (w_more) begin
              r_state <= StData;
              r_mode  <= MODE_IDATA;
              r_ack   <= 1'b1;
              r_sent  <= r_sent + 5'd1;
            end else begin
              r_state <= StTgb;
              r_mode  <= MODE_IGB;
            end
          end
          StTgb: begin
            if (r_cnt != 5'd1) begin
              r_state <= StTgb;
              r_cnt   <= r_cnt + 5'd1;
              r_mode  <= MODE_IGB;
              r_ctl   <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign packet_ack   = r_ack;
  assign packet_pixel = r_pix;
  assign guard_lead   = r_lead;

`else

  logic w_unused;
  assign w_unused = packet_req | (MAX_PACKETS == 0);

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_mode <= MODE_CTRL;
      r_ctl  <= '0;
    end else begin
      r_mode <= w_vid_mode;
      r_ctl  <= w_vid_ctl;
    end
  end

  assign packet_ack   = 1'b0;
  assign packet_pixel = 5'd0;
  assign guard_lead   = 1'b0;

`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: decode vector table, directed island sequences and random
// stimulus checked against a cycle-age reference model (default and MAX_PACKETS=1 instances).
`timescale 1ns/1ps
module tb_hdmi_period_scheduler;

`ifdef HDMI_DATA_ISLAND_EN
  localparam bit IslandEn = 1'b1;
`else
  localparam bit IslandEn = 1'b0;
`endif

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int FW = 800;
  localparam int FH = 525;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        req;
  logic        req_m1;
  logic        ack0, ack1;
  logic [2:0]  mode0, mode1;
  logic [3:0]  ctl0, ctl1;
  logic [4:0]  pix0, pix1;
  logic        lead0, lead1;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_period_scheduler dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .cx          (cx),
    .cy          (cy),
    .packet_req  (req),
    .packet_ack  (ack0),
    .mode        (mode0),
    .ctl         (ctl0),
    .packet_pixel(pix0),
    .guard_lead  (lead0)
  );

  hdmi_period_scheduler #(.MAX_PACKETS(1)) dut_m1 (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .cx          (cx),
    .cy          (cy),
    .packet_req  (req_m1),
    .packet_ack  (ack1),
    .mode        (mode1),
    .ctl         (ctl1),
    .packet_pixel(pix1),
    .guard_lead  (lead1)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] ctl;
    logic       ack;
    logic [4:0] pix;
    logic       lead;
  } outs_t;

  typedef struct {
    int cx;
    int cy;
    int mode;
    int ctl;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: island progress is tracked as cycles elapsed since the island began.
  bit    m_active [2];
  int    m_age    [2];
  int    m_tgb    [2];
  int    m_sent   [2];
  outs_t m_exp    [2];

  int rec_mode0 [FW];
  int rec_pix0  [FW];
  int rec_lead0 [FW];
  int rec_mode1 [FW];
  int ref_line10 [FW];
  int acks0;
  int acks1;

  function automatic outs_t mk(int m, int c, bit a, int p, bit l);
    outs_t o;
    o.mode = 3'(m);
    o.ctl  = 4'(c);
    o.ack  = a;
    o.pix  = 5'(p);
    o.lead = l;
    return o;
  endfunction

  function automatic outs_t video_outs(int x, int y);
    bit vnext;
    vnext = (y == FH - 1) || (y < SH - 1);
    if (x < SW && y < SH) return mk(3, 0, 0, 0, 0);
    if (vnext && x >= FW - 10 && x <= FW - 3) return mk(1, 1, 0, 0, 0);
    if (vnext && x >= FW - 2 && x <= FW - 1) return mk(2, 0, 0, 0, 0);
    return mk(0, 0, 0, 0, 0);
  endfunction

  function automatic void model_step(int i, int x, int y, bit r, bit rst, int maxp);
    outs_t o;
    int d;
    o = video_outs(x, y);
    if (!rst) begin
      m_active[i] = 1'b0;
      o = '0;
    end else if (m_active[i] && x < SW) begin
      m_active[i] = 1'b0;
    end else if (m_active[i]) begin
      m_age[i]++;
      if (m_age[i] < 8) begin
        o = mk(4, 5, 0, 0, 0);
      end else if (m_age[i] < 10) begin
        o = mk(5, 0, 0, 0, 1);
      end else if (m_tgb[i] < 0) begin
        d = m_age[i] - 10;
        if (d % 32 != 0) begin
          o = mk(6, 0, 0, d % 32, 0);
        end else if (d == 0 || (r && m_sent[i] < maxp && x + 1 + 48 <= FW)) begin
          m_sent[i]++;
          o = mk(6, 0, 1, 0, 0);
        end else begin
          m_tgb[i] = m_age[i];
          o = mk(5, 0, 0, 0, 0);
        end
      end else if (m_age[i] - m_tgb[i] < 2) begin
        o = mk(5, 0, 0, 0, 0);
      end else begin
        m_active[i] = 1'b0;
      end
    end else if (IslandEn && x == SW + 4 && r && SW + 62 <= FW) begin
      m_active[i] = 1'b1;
      m_age[i]    = 0;
      m_tgb[i]    = -1;
      m_sent[i]   = 0;
      o = mk(4, 5, 0, 0, 0);
    end
    m_exp[i] = o;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got mode=%0d ctl=%b ack=%b pix=%0d lead=%b, want mode=%0d ctl=%b ack=%b pix=%0d lead=%b",
               name, got.mode, got.ctl, got.ack, got.pix, got.lead,
               exp.mode, exp.ctl, exp.ack, exp.pix, exp.lead);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step(input int x, input int y, input bit r0, input bit r1, input bit rst);
    cx      = 12'(x);
    cy      = 11'(y);
    req     = r0;
    req_m1  = r1;
    reset_n = rst;
    @(posedge clk_pixel);
    #1;
    model_step(0, x, y, r0, rst, 18);
    model_step(1, x, y, r1, rst, 1);
    check($sformatf("dut cx=%0d cy=%0d", x, y), {mode0, ctl0, ack0, pix0, lead0}, m_exp[0]);
    check($sformatf("dut_m1 cx=%0d cy=%0d", x, y), {mode1, ctl1, ack1, pix1, lead1}, m_exp[1]);
  endtask

  // src < 0: req held high; src >= 0: a source holding that many packets.
  task automatic walk_line(input int y, input int src, input int x0, input int x1);
    int  pend;
    bit  r;
    pend  = src;
    acks0 = 0;
    acks1 = 0;
    for (int x = x0; x <= x1; x++) begin
      r = (src < 0) ? 1'b1 : (pend > 0);
      step(x, y, r, 1'b1, 1'b1);
      rec_mode0[x] = int'(mode0);
      rec_pix0[x]  = int'(pix0);
      rec_lead0[x] = int'(lead0);
      rec_mode1[x] = int'(mode1);
      if (ack0) begin
        acks0++;
        if (pend > 0) pend--;
      end
      if (ack1) acks1++;
    end
  endtask

  function automatic int count_island(int x0, int x1);
    int n;
    n = 0;
    for (int x = x0; x <= x1; x++) if (rec_mode0[x] >= 4) n++;
    return n;
  endfunction

  function automatic int count_mode(int m);
    int n;
    n = 0;
    for (int x = 0; x < FW; x++) if (rec_mode0[x] == m) n++;
    return n;
  endfunction

  initial begin
    vec_t vecs [16];
    int   lines [8];
    int   x, y, diffs;
    bit   r, rst, vn;

    vecs[0]  = '{0, 0, 3, 0};     vecs[1]  = '{639, 0, 3, 0};
    vecs[2]  = '{640, 0, 0, 0};   vecs[3]  = '{639, 479, 3, 0};
    vecs[4]  = '{0, 480, 0, 0};   vecs[5]  = '{789, 10, 0, 0};
    vecs[6]  = '{790, 10, 1, 1};  vecs[7]  = '{797, 10, 1, 1};
    vecs[8]  = '{798, 10, 2, 0};  vecs[9]  = '{799, 10, 2, 0};
    vecs[10] = '{790, 478, 1, 1}; vecs[11] = '{790, 479, 0, 0};
    vecs[12] = '{795, 524, 1, 1}; vecs[13] = '{799, 524, 2, 0};
    vecs[14] = '{798, 500, 0, 0}; vecs[15] = '{644, 200, 0, 0};
    lines = '{0, 10, 478, 479, 480, 500, 523, 524};

    step(700, 10, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    check("reset state", {mode0, ctl0, ack0, pix0, lead0}, mk(0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].cx, vecs[i].cy, 1'b0, 1'b1, 1'b1);
      check($sformatf("vector %0d", i), {mode0, ctl0, ack0, pix0, lead0},
            mk(vecs[i].mode, vecs[i].ctl, 0, 0, 0));
    end

    foreach (lines[i]) begin
      walk_line(lines[i], 0, 0, FW - 1);
      vn = (lines[i] == FH - 1) || (lines[i] < SH - 1);
      check_int($sformatf("video px cy=%0d", lines[i]), count_mode(3), (lines[i] < SH) ? SW : 0);
      check_int($sformatf("vpre px cy=%0d", lines[i]), count_mode(1), vn ? 8 : 0);
      check_int($sformatf("vgb px cy=%0d", lines[i]), count_mode(2), vn ? 2 : 0);
      check_int($sformatf("no island cy=%0d", lines[i]), count_island(0, FW - 1), 0);
      if (lines[i] == 10) for (int k = 0; k < FW; k++) ref_line10[k] = rec_mode0[k];
    end

`ifdef HDMI_DATA_ISLAND_EN
    walk_line(10, -1, 0, FW - 1);
    check_int("ctrl 643", rec_mode0[643], 0);
    check_int("ipre 644", rec_mode0[644], 4);
    check_int("ipre 651", rec_mode0[651], 4);
    check_int("lgb 652", rec_mode0[652], 5);
    check_int("lgb lead 653", rec_lead0[653], 1);
    check_int("data 654", rec_mode0[654], 6);
    check_int("pkt2 start pix", rec_pix0[686], 0);
    check_int("pkt4 last pix", rec_pix0[781], 31);
    check_int("tgb 782", rec_mode0[782], 5);
    check_int("tgb lead 783", rec_lead0[783], 0);
    check_int("ctrl 784", rec_mode0[784], 0);
    check_int("vpre 790", rec_mode0[790], 1);
    check_int("ack count 4", acks0, 4);
    check_int("m1 data 685", rec_mode1[685], 6);
    check_int("m1 tgb 686", rec_mode1[686], 5);
    check_int("m1 ctrl 688", rec_mode1[688], 0);
    check_int("m1 ack count", acks1, 1);

    walk_line(11, 2, 0, FW - 1);
    check_int("src2 data 717", rec_mode0[717], 6);
    check_int("src2 tgb 718", rec_mode0[718], 5);
    check_int("src2 tgb 719", rec_mode0[719], 5);
    check_int("src2 ctrl 720", rec_mode0[720], 0);
    check_int("src2 acks", acks0, 2);
    walk_line(12, 0, 0, FW - 1);
    check_int("src2 next line idle", count_island(0, FW - 1), 0);

    walk_line(13, -1, 0, 669);
    check_int("mid pix 15", rec_pix0[669], 15);
    step(670, 13, 1'b1, 1'b1, 1'b0);
    check("mid-island reset", {mode0, ctl0, ack0, pix0, lead0}, mk(0, 0, 0, 0, 0));
    walk_line(13, -1, 671, FW - 1);
    check_int("no restart after reset", count_island(671, FW - 1), 0);
    walk_line(14, -1, 0, FW - 1);
    check_int("restart 643 ctrl", rec_mode0[643], 0);
    check_int("restart 644 ipre", rec_mode0[644], 4);
`else
    walk_line(10, -1, 0, FW - 1);
    check_int("dvi no ack", acks0, 0);
    check_int("dvi m1 no ack", acks1, 0);
    check_int("dvi no island", count_island(0, FW - 1), 0);
    diffs = 0;
    for (int k = 0; k < FW; k++) if (rec_mode0[k] != ref_line10[k]) diffs++;
    check_int("dvi same as req=0 line", diffs, 0);
`endif

    x = 600;
    y = 20;
    r = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        x = ($urandom_range(0, 1) == 0) ? $urandom_range(630, 700) : $urandom_range(0, FW - 1);
      end else if (x == FW - 1) begin
        x = 0;
        y = (y == FH - 1) ? 0 : y + 1;
      end else begin
        x++;
      end
      if ($urandom_range(0, 299) == 0) y = $urandom_range(0, FH - 1);
      if ($urandom_range(0, 15) == 0) r = ~r;
      rst = ($urandom_range(0, 2999) != 0);
      step(x, y, r, $urandom_range(0, 3) != 0, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
